// File: rtl/jump_ctrl_if.sv
// Request and redirect signal bundle for jump_ctrl.
// master: decode/fetch side; slave: jump_ctrl.
interface jump_ctrl_if #(
  parameter int XLEN     = 32,
  parameter int OFFSET_W = 26
);
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          kind;
  logic [OFFSET_W-1:0] jump_offset;
  logic [15:0]         branch_imm;
  logic [XLEN-1:0]     next_pc;
  logic [XLEN-1:0]     rs_val;
  logic [XLEN-1:0]     rt_val;
  logic [4:0]          rs_idx;
  logic                redir_valid;
  logic                redir_ready;
  logic [XLEN-1:0]     redir_pc;
  logic                link_valid;
  logic [XLEN-1:0]     link_addr;
  logic                flush;
  logic                ras_hit;

  modport master (
    output req_valid, kind, jump_offset, branch_imm, next_pc, rs_val, rt_val,
           rs_idx, redir_ready,
    input  req_ready, redir_valid, redir_pc, link_valid, link_addr, flush, ras_hit
  );

  modport slave (
    input  req_valid, kind, jump_offset, branch_imm, next_pc, rs_val, rt_val,
           rs_idx, redir_ready,
    output req_ready, redir_valid, redir_pc, link_valid, link_addr, flush, ras_hit
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump/branch resolution: registered PC redirect then FLUSH_CYCLES of flush; optional RAS via JUMP_CTRL_RAS_EN.
// Latency: accept at edge N -> redir_valid in cycle N+1; flush follows the redirect handshake.
// Backpressure: redirect held stable until redir_ready; req_ready low from accept until flush ends.
module jump_ctrl #(
  parameter int XLEN         = 32,
  parameter int OFFSET_W     = 26,
  parameter int FLUSH_CYCLES = 2,
  parameter int RAS_DEPTH    = 4
) (
  input logic        clk,
  input logic        rst_n,
  jump_ctrl_if.slave bus
);

  localparam logic [2:0] K_J   = 3'd1;
  localparam logic [2:0] K_JAL = 3'd2;
  localparam logic [2:0] K_JR  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_BNE = 3'd5;

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic             req_ready_q;
  logic             redir_valid_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic             link_valid_q;
  logic [XLEN-1:0]  link_addr_q;
  logic             flush_q;
  logic             ras_hit_q;

  logic             accept;
  logic             taken;
  logic             is_jal;
  logic             is_jr31;
  logic             ras_hit_nxt;
  logic [XLEN-1:0]  tgt;
  logic [XLEN-1:0]  j_target;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  link_nxt;
  logic signed [17:0] imm_x4;

  assign accept = bus.req_valid && req_ready_q;

  always_comb begin
    j_target  = {bus.next_pc[XLEN-1:OFFSET_W+2], bus.jump_offset, 2'b00};
    imm_x4    = {bus.branch_imm, 2'b00};
    // Signed size cast sign-extends (or wraps) the displacement to XLEN.
    br_target = bus.next_pc + XLEN'(imm_x4);
    link_nxt  = bus.next_pc + XLEN'(4);
    taken     = 1'b0;
    tgt       = j_target;
    is_jal    = 1'b0;
    is_jr31   = 1'b0;
    case (bus.kind)
      K_J:   taken = 1'b1;
      K_JAL: begin
        taken  = 1'b1;
        is_jal = 1'b1;
      end
      K_JR: begin
        taken   = 1'b1;
        tgt     = bus.rs_val;
        is_jr31 = (bus.rs_idx == 5'd31);
      end
      K_BEQ: begin
        taken = (bus.rs_val == bus.rt_val);
        tgt   = br_target;
      end
      K_BNE: begin
        taken = (bus.rs_val != bus.rt_val);
        tgt   = br_target;
      end
      default: ;
    endcase
  end

`ifdef JUMP_CTRL_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic [PTR_W-1:0] top_idx;

  // ras_ptr is the next write slot; the top of stack sits just below it.
  assign top_idx     = ras_ptr - PTR_W'(1);
  assign ras_hit_nxt = is_jr31 && (ras_cnt != '0) && (ras_mem[top_idx] == bus.rs_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (accept && is_jal) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
    end else if (accept && is_jr31 && (ras_cnt != '0)) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_jal) ras_mem[ras_ptr] <= link_nxt;
  end
`else
  logic unused_ras;
  assign unused_ras  = is_jr31 & (RAS_DEPTH > 1);
  assign ras_hit_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      req_ready_q   <= 1'b1;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      link_valid_q  <= 1'b0;
      link_addr_q   <= '0;
      flush_q       <= 1'b0;
      ras_hit_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Not-taken requests are consumed here without touching any output.
          if (accept && taken) begin
            state         <= HOLD;
            req_ready_q   <= 1'b0;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= tgt;
            link_valid_q  <= is_jal;
            link_addr_q   <= link_nxt;
            ras_hit_q     <= ras_hit_nxt;
          end
        end
        HOLD: begin
          if (bus.redir_ready) begin
            redir_valid_q <= 1'b0;
            link_valid_q  <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
              state     <= FLUSH;
              flush_q   <= 1'b1;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state       <= IDLE;
            flush_q     <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          flush_q     <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.link_valid  = link_valid_q;
  assign bus.link_addr   = link_addr_q;
  assign bus.flush       = flush_q;
  assign bus.ras_hit     = ras_hit_q;

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Parametrised jump/branch resolution stage for the MIPS core, generalising the combinational J-target unit. Accepts one resolved control-flow request per handshake and computes the target for J, JAL, JR, BEQ and BNE. Drives a registered, back-pressurable PC redirect followed by a programmable pipeline flush window. Optionally maintains a return-address stack (RAS) for JAL/JR pairing.

## Interface
- `XLEN`, default 32: PC/data width; must be ≥ `OFFSET_W`+4.
- `OFFSET_W`, default 26: J-type offset width.
- `FLUSH_CYCLES`, default 2: `flush` cycles after each accepted redirect; 0 is legal.
- `RAS_DEPTH`, default 4: RAS entries; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both high.
- `kind` in 3: 0 NONE, 1 J, 2 JAL, 3 JR, 4 BEQ, 5 BNE; 6–7 treated as NONE.
- `jump_offset` in `OFFSET_W`: J/JAL target field.
- `branch_imm` in 16: branch immediate, signed.
- `next_pc` in `XLEN`: PC of the instruction + 4.
- `rs_val`, `rt_val` in `XLEN`: operand values.
- `rs_idx` in 5: JR source register number.
- `redir_valid` out 1: redirect pending.
- `redir_ready` in 1: fetch accepts the redirect.
- `redir_pc` out `XLEN`: target.
- `link_valid` out 1: qualifies `link_addr`; high with `redir_valid` for JAL only.
- `link_addr` out `XLEN`: `next_pc`+4, for the $31 write.
- `flush` out 1: kill younger instructions.
- `ras_hit` out 1: JR($31) target matched the RAS top; valid with `redir_valid`.

## Operation
- FSM states: IDLE, HOLD, FLUSH. `req_ready` = (state == IDLE).
- Targets:
  - J/JAL: {`next_pc`[XLEN-1:OFFSET_W+2], `jump_offset`, 2'b00}.
  - JR: `rs_val`.
  - Branch: `next_pc` + (sign-extended `branch_imm` << 2), modulo 2^XLEN.
- Taken rules: J, JAL and JR are always taken. BEQ is taken if `rs_val` == `rt_val`; BNE is taken if they differ.
- Accepted and taken: capture `redir_pc`, `link_valid`, `link_addr`, `ras_hit`; go to HOLD.
- Accepted and not taken, or NONE: consumed silently; remain IDLE; no output change.
- HOLD: `redir_valid`=1; all redirect outputs are held stable until `redir_ready`=1.
- On `redir_ready`=1 in HOLD: go to FLUSH if `FLUSH_CYCLES`>0, else IDLE.
- FLUSH: `flush`=1 for exactly `FLUSH_CYCLES` cycles via a down-counter, then IDLE.
- Outside HOLD, `redir_valid` and `link_valid` are 0. `redir_pc`, `link_addr` and `ras_hit` keep their last values.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except `req_ready`=1; RAS count and pointer 0.
- Reset asserted mid-HOLD or mid-FLUSH aborts the operation; no redirect is replayed.
- Latency: request accepted at edge N gives `redir_valid`=1 in cycle N+1. If `redir_ready` is already high in cycle N+1, `flush` is high in cycles N+2 through N+1+`FLUSH_CYCLES`. `req_ready` returns high the following cycle.
- Throughput: one taken request per (2 + `FLUSH_CYCLES`) cycles minimum. Not-taken requests are accepted back-to-back, one per cycle.
- `redir_ready` is ignored outside HOLD.
- `redir_valid` must not drop before acceptance.

## Configuration
Macro: `JUMP_CTRL_RAS_EN`.

With the macro defined:
- Circular RAS of `RAS_DEPTH` entries, with a saturating count (0..`RAS_DEPTH`).
- Accepted JAL pushes `link_addr`. A push when full overwrites the oldest entry; the count stays at `RAS_DEPTH`.
- Accepted JR with `rs_idx`=31 pops the stack. `ras_hit` = (count>0 and top == `rs_val`).
- A pop when empty leaves the pointer and count unchanged and gives `ras_hit`=0.
- JR with any other `rs_idx` leaves the RAS untouched.
- RAS updates occur at the accept edge.

Without the macro: no RAS storage; `ras_hit` is tied to 0; everything else is identical.

## Test plan
- J, `jump_offset`=26'h3, `next_pc`=32'h4, `redir_ready`=1 → next cycle `redir_valid`=1, `redir_pc`=32'h0000000C, `link_valid`=0; then `flush` high for 2 cycles; then `req_ready`=1.
- JAL, `next_pc`=32'h40000010, offset 26'h100 → `redir_pc`=32'h40000400, `link_valid`=1, `link_addr`=32'h40000014.
- BEQ, `rs_val`=`rt_val`=5, imm 16'hFFFE, `next_pc`=32'h100 → `redir_pc`=32'hF8. BNE with the same operands → no redirect, `req_ready` remains 1 the next cycle.
- Back-pressure: taken J with `redir_ready`=0 for 3 cycles → `redir_valid` and `redir_pc` stable and `req_ready`=0 throughout; `flush` starts only after the acceptance cycle.
- RAS (macro on, depth 4): five JALs with link addresses A1..A5. Then four JR $31 with matching `rs_val` → `ras_hit`=1 for A5, A4, A3, A2. A fifth JR → `ras_hit`=0.
- Async reset: `rst_n` low during HOLD → `redir_valid`, `flush` and `link_valid` drop to 0 immediately. After release, `req_ready`=1 and the RAS is empty.
